// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32IM core types and constants
package rv32_pkg;

  localparam logic [31:0] NOP_INS = 32'h00000013;

  typedef enum logic {
    FETCH_RUN,
    FETCH_FAULT
  } fetch_state_t;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, imem address drive and registered valid/ready output to decode
module instruction_fetch
  import rv32_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [31:0]           if_ins,
  output logic [ADDR_WIDTH-1:0] if_pc,
  output logic                  fetch_fault
);

  localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

  fetch_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  valid_q, valid_d;
  logic [31:0]           ins_q, ins_d;
  logic [ADDR_WIDTH-1:0] ins_pc_q, ins_pc_d;

  logic take;
  logic slot_free;

  assign take      = valid_q & if_ready;
  assign slot_free = ~valid_q | take;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FETCH_RUN;
      pc_q     <= RESET_PC;
      valid_q  <= 1'b0;
      ins_q    <= NOP_INS;
      ins_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      valid_q  <= valid_d;
      ins_q    <= ins_d;
      ins_pc_q <= ins_pc_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    valid_d  = valid_q;
    ins_d    = ins_q;
    ins_pc_d = ins_pc_q;

    unique case (state_q)
      FETCH_RUN: begin
        // A redirect flushes whatever is in the slot; if decode took it this
        // cycle the handshake already completed, otherwise it is discarded.
        if (redirect_valid) begin
          valid_d = 1'b0;
          if (is_word_aligned(redirect_pc[1:0])) begin
            pc_d = redirect_pc;
          end else begin
            state_d = FETCH_FAULT;
          end
        end else if (slot_free) begin
          ins_d    = imem_data;
          ins_pc_d = pc_q;
          valid_d  = 1'b1;
          pc_d     = pc_q + PC_STEP;
        end
      end
      FETCH_FAULT: begin
        valid_d = 1'b0;
      end
      default: begin
        state_d = FETCH_FAULT;
        valid_d = 1'b0;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign if_valid    = valid_q;
  assign if_ins      = ins_q;
  assign if_pc       = ins_pc_q;
  assign fetch_fault = (state_q == FETCH_FAULT);

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed and randomized checks of instruction_fetch against a behavioural model
module tb_instruction_fetch;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          if_valid;
  logic          if_ready;
  logic [31:0]   if_ins;
  logic [AW-1:0] if_pc;
  logic          fetch_fault;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem [0:63];

  // model state
  logic [AW-1:0] m_pc;
  logic          m_valid;
  logic [31:0]   m_ins;
  logic [AW-1:0] m_ins_pc;
  logic          m_fault;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[AW-1:2]];

  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ins         (if_ins),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: what the fetch stage must present after each edge.
  always @(posedge clk) begin
    if (rst) begin
      m_pc = '0; m_valid = 1'b0; m_ins = 32'h00000013; m_ins_pc = '0; m_fault = 1'b0;
    end else if (m_fault) begin
      m_valid = 1'b0;
    end else if (redirect_valid) begin
      m_valid = 1'b0;
      if (redirect_pc % 4 != 0) m_fault = 1'b1;
      else m_pc = redirect_pc;
    end else if (!m_valid || if_ready) begin
      m_ins    = mem[m_pc / 4];
      m_ins_pc = m_pc;
      m_valid  = 1'b1;
      m_pc     = AW'((int'(m_pc) + 4) % 256);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("imem_addr", 32'(imem_addr), 32'(m_pc));
      chk("if_valid", 32'(if_valid), 32'(m_valid));
      chk("if_ins", if_ins, m_ins);
      chk("if_pc", 32'(if_pc), 32'(m_ins_pc));
      chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
      if (if_valid && if_ready)
        chk("taken_word", if_ins, mem[if_pc[AW-1:2]]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'hFEDCB0B7;
    mem[1] = 32'h78900113;
    mem[2] = 32'h001100B3;
    rst = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    chk_en = 1'b1;
    step();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_ins", if_ins, 32'h00000013);
    chk("rst_pc", 32'(if_pc), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_fault", 32'(fetch_fault), 32'd0);

    // sequential fetch and stall
    rst = 1'b0;
    step();
    chk("seq0_ins", if_ins, 32'hFEDCB0B7);
    chk("seq0_pc", 32'(if_pc), 32'h00);
    step();
    chk("seq1_ins", if_ins, 32'h78900113);
    chk("seq1_pc", 32'(if_pc), 32'h04);
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_ins", if_ins, 32'h78900113);
      chk("stall_pc", 32'(if_pc), 32'h04);
      chk("stall_addr", 32'(imem_addr), 32'h08);
    end
    if_ready = 1'b1;
    step();
    chk("seq2_ins", if_ins, 32'h001100B3);
    chk("seq2_pc", 32'(if_pc), 32'h08);

    // redirect concurrent with take on pc 4
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    chk("pre_redir_pc", 32'(if_pc), 32'h04);
    redirect_valid = 1'b1; redirect_pc = 8'h20;
    step();
    redirect_valid = 1'b0;
    chk("redir_flush", 32'(if_valid), 32'd0);
    step();
    chk("redir_valid", 32'(if_valid), 32'd1);
    chk("redir_pc", 32'(if_pc), 32'h20);

    // misaligned redirect faults; later redirect ignored
    redirect_valid = 1'b1; redirect_pc = 8'h22;
    step();
    chk("fault_set", 32'(fetch_fault), 32'd1);
    chk("fault_valid", 32'(if_valid), 32'd0);
    redirect_pc = 8'h10;
    step();
    redirect_valid = 1'b0;
    step(); step();
    chk("fault_sticky", 32'(fetch_fault), 32'd1);
    chk("fault_valid2", 32'(if_valid), 32'd0);
    chk("fault_pc_frozen", 32'(imem_addr), 32'h24);
    rst = 1'b1; step(); rst = 1'b0;
    chk("fault_clear", 32'(fetch_fault), 32'd0);
    chk("fault_restart", 32'(imem_addr), 32'd0);

    // wrap-around
    redirect_valid = 1'b1; redirect_pc = 8'hFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_fc", 32'(if_pc), 32'hFC);
    step();
    chk("wrap_00", 32'(if_pc), 32'h00);
    chk("wrap_ins", if_ins, 32'hFEDCB0B7);

    // reset during stall
    if_ready = 1'b0;
    step();
    chk("stall_hold_valid", 32'(if_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_stall_valid", 32'(if_valid), 32'd0);
    chk("rst_stall_ins", if_ins, 32'h00000013);
    chk("rst_stall_addr", 32'(imem_addr), 32'd0);

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = (r < 10);
      if (r < 2) redirect_pc = {6'($urandom_range(0, 63)), 2'($urandom_range(1, 3))};
      else       redirect_pc = {6'($urandom_range(0, 63)), 2'b00};
      rst = (r >= 98);
      step();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    step();
    chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
